// File: rtl/word_replicator.sv
// Stream stage that widens IN_WIDTH-bit words into FACTOR-lane output words,
// either replicating one word across every lane or packing successive words MSB lane first.
module word_replicator #(
    parameter int IN_WIDTH = 8,
    parameter int FACTOR   = 2,
    parameter int CNT_W    = $clog2(FACTOR + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IN_WIDTH*FACTOR-1:0]   out_data,
    output logic [CNT_W-1:0]             out_count
);

    localparam int OUT_W = IN_WIDTH * FACTOR;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  count, count_next, count_inc;
    logic [CNT_W-1:0]  out_count_next;
    logic [OUT_W-1:0]  acc, acc_next, acc_fill;
    logic [OUT_W-1:0]  out_data_next;
    logic              mode_q, mode_next, mode_eff;
    logic              accept;

    // Word number 'filled' (0-based) lands in lane FACTOR-1-filled.
    function automatic logic [OUT_W-1:0] place_lane(input logic [OUT_W-1:0]    base,
                                                    input logic [IN_WIDTH-1:0] word,
                                                    input logic [CNT_W-1:0]    filled);
        logic [OUT_W-1:0] r;
        r = base;
        for (int k = 0; k < FACTOR; k++) begin
            if (int'(filled) == k) r[(FACTOR-1-k)*IN_WIDTH +: IN_WIDTH] = word;
        end
        return r;
    endfunction

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= COLLECT;
            count     <= '0;
            acc       <= '0;
            mode_q    <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            acc       <= acc_next;
            mode_q    <= mode_next;
            out_data  <= out_data_next;
            out_count <= out_count_next;
        end
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        acc_next       = acc;
        mode_next      = mode_q;
        out_data_next  = out_data;
        out_count_next = out_count;

        accept    = in_valid && (state == COLLECT);
        // Mode is only honoured at the start of a word group.
        mode_eff  = (count == '0) ? mode : mode_q;
        count_inc = count + 1'b1;
        acc_fill  = place_lane(acc, in_data, count);

        case (state)
            COLLECT: begin
                if (accept) begin
                    if (count == '0) mode_next = mode;
                    if (!mode_eff) begin
                        out_data_next  = {FACTOR{in_data}};
                        out_count_next = CNT_W'(FACTOR);
                        state_next     = HOLD;
                    end else if ((count_inc == CNT_W'(FACTOR)) || flush) begin
                        out_data_next  = acc_fill;
                        out_count_next = count_inc;
                        count_next     = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next   = acc_fill;
                        count_next = count_inc;
                    end
                end else if (mode_eff && flush && (count != '0)) begin
                    out_data_next  = acc;
                    out_count_next = count;
                    count_next     = '0;
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = COLLECT;
                    acc_next   = '0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_word_replicator.sv
// Randomized and directed bench for word_replicator at FACTOR=2 and FACTOR=4,
// both instances fed the same stream and compared against a lane-list reference model.
module tb_word_replicator;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode, flush, in_valid, out_ready;
    logic [7:0]  in_data;

    logic        rdy2, ov2;
    logic [15:0] od2;
    logic [1:0]  oc2;
    logic        rdy4, ov4;
    logic [31:0] od4;
    logic [2:0]  oc4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, a list of collected words and the held output.
    bit          mhold [2];
    bit          mpm   [2];
    logic [31:0] mdata [2];
    int          mcnt  [2];
    logic [7:0]  mlanes[2][4];
    int          mlen  [2];

    always #5 clk = ~clk;

    word_replicator #(.IN_WIDTH(8), .FACTOR(2)) dut2 (
        .clk(clk), .reset(reset), .mode(mode), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_count(oc2)
    );

    word_replicator #(.IN_WIDTH(8), .FACTOR(4)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_count(oc4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fac(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mhold[i] = 1'b0;
            mpm[i]   = 1'b0;
            mdata[i] = '0;
            mcnt[i]  = 0;
            mlen[i]  = 0;
        end
    endtask

    task automatic model_emit(input int i);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < mlen[i]; k++)
            r = r | (32'(mlanes[i][k]) << (8 * (fac(i) - 1 - k)));
        mdata[i] = r;
        mcnt[i]  = mlen[i];
        mlen[i]  = 0;
        mhold[i] = 1'b1;
    endtask

    task automatic model_edge(input int i);
        logic [31:0] r;
        if (mhold[i]) begin
            if (out_ready) mhold[i] = 1'b0;
        end else if (in_valid) begin
            if (mlen[i] == 0) mpm[i] = mode;
            if (!mpm[i]) begin
                r = '0;
                for (int k = 0; k < fac(i); k++) r = (r << 8) | 32'(in_data);
                mdata[i] = r;
                mcnt[i]  = fac(i);
                mhold[i] = 1'b1;
            end else begin
                mlanes[i][mlen[i]] = in_data;
                mlen[i]++;
                if (mlen[i] == fac(i) || flush) model_emit(i);
            end
        end else if (mpm[i] && flush && mlen[i] > 0) begin
            model_emit(i);
        end
    endtask

    task automatic compare_all();
        chk("rdy2",  32'(rdy2), 32'(!mhold[0]));
        chk("ov2",   32'(ov2),  32'(mhold[0]));
        chk("data2", 32'(od2),  mdata[0]);
        chk("cnt2",  32'(oc2),  32'(mcnt[0]));
        chk("rdy4",  32'(rdy4), 32'(!mhold[1]));
        chk("ov4",   32'(ov4),  32'(mhold[1]));
        chk("data4", od4,       mdata[1]);
        chk("cnt4",  32'(oc4),  32'(mcnt[1]));
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic iv, input logic md, input logic fl, input logic ord,
                        input logic [7:0] d);
        in_valid  = iv;
        mode      = md;
        flush     = fl;
        out_ready = ord;
        in_data   = d;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; mode = 1'b0; in_data = '0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; mode = 1'b0; in_data = '0;
        reset = 1'b0;
        model_reset();
        #12;
        chk("rst_ov2",   32'(ov2), 32'd0);
        chk("rst_data4", od4,      32'd0);
        chk("rst_cnt4",  32'(oc4), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_rdy2", 32'(rdy2), 32'd1);

        // Replicate one word
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h7B);
        chk("rep_ov2",   32'(ov2),  32'd1);
        chk("rep_data2", 32'(od2),  32'h7B7B);
        chk("rep_cnt2",  32'(oc2),  32'd2);
        chk("rep_rdy2",  32'(rdy2), 32'd0);
        chk("rep_data4", od4,       32'h7B7B7B7B);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Full pack, back-to-back
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h44);
        chk("pack_ov4",   32'(ov4), 32'd1);
        chk("pack_data4", od4,      32'h11223344);
        chk("pack_cnt4",  32'(oc4), 32'd4);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("pack_pulse4", 32'(ov4), 32'd0);

        // Flush on the second word
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hBB);
        chk("flush_data4", od4,       32'hAABB0000);
        chk("flush_cnt4",  32'(oc4),  32'd2);
        chk("flush_data2", 32'(od2),  32'hAABB);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);

        // Flush with nothing collected does nothing
        do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("flush0_ov4", 32'(ov4), 32'd0);
        chk("flush0_ov2", 32'(ov2), 32'd0);

        // Back-pressure in HOLD
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5C);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
            chk("bp_data4", od4,       32'h5C5C5C5C);
            chk("bp_rdy4",  32'(rdy4), 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h66);
        chk("bp_rel_ov4",  32'(ov4),  32'd0);
        chk("bp_rel_rdy4", 32'(rdy4), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
        chk("bp_next4", od4, 32'h66666666);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Mode change mid-pack is ignored
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
        chk("mchg_data2", 32'(od2), 32'h0102);
        chk("mchg_cnt2",  32'(oc2), 32'd2);
        chk("mchg_ov2",   32'(ov2), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Asynchronous reset between edges
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_ov2",   32'(ov2), 32'd0);
        chk("arst_data2", 32'(od2), 32'd0);
        chk("arst_cnt2",  32'(oc2), 32'd0);
        model_reset();
        #1;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0A);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0B);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0C);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0D);
        chk("arst_pack4", od4, 32'h0A0B0C0D);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
